// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipeline: decodes scan counters into syncs/blanking, fetches 4x-upscaled
// pixels from a double-buffered 160x120 RGB444 framebuffer, and delay-matches everything to the DAC.
module vga_pixel_pipe #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [9:0]        hcnt_i,
    input  logic [9:0]        vcnt_i,
    input  logic              fb_sel_req_i,
    input  logic              pattern_en_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_en_o,
    input  logic [11:0]       mem_data_i,
    output logic [3:0]        vga_r_o,
    output logic [3:0]        vga_g_o,
    output logic [3:0]        vga_b_o,
    output logic              vga_hs_o,
    output logic              vga_vs_o,
    output logic              vblank_o,
    output logic              frame_start_o,
    output logic              fb_sel_cur_o
);

    typedef struct packed {
        logic       active;
        logic       hs_n;
        logic       vs_n;
        logic       vb;
        logic       fs;
        logic [9:0] h;
    } tag_t;

    localparam tag_t TAG_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                                  vb: 1'b0, fs: 1'b0, h: 10'd0};

    // Stage 0: combinational decode of the incoming scan position
    logic in_range;
    tag_t tag0;

    always_comb begin
        in_range    = (hcnt_i < 10'd800) && (vcnt_i < 10'd521);
        tag0        = TAG_IDLE;
        tag0.active = (hcnt_i < 10'd640) && (vcnt_i < 10'd480);
        tag0.hs_n   = !(in_range && (hcnt_i >= 10'd656) && (hcnt_i <= 10'd751));
        tag0.vs_n   = !(in_range && (vcnt_i >= 10'd490) && (vcnt_i <= 10'd491));
        tag0.vb     = (vcnt_i >= 10'd480);
        tag0.fs     = (hcnt_i == 10'd0) && (vcnt_i == 10'd0);
        tag0.h      = hcnt_i;
    end

    // Stage 1: framebuffer address, y*160 built from two shifts
    logic [14:0] y_ext;
    logic [14:0] x_ext;
    logic [14:0] pix_idx;

    assign y_ext   = {7'd0, vcnt_i[9:2]};
    assign x_ext   = {7'd0, hcnt_i[9:2]};
    assign pix_idx = (y_ext << 7) + (y_ext << 5) + x_ext;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_en_q;
    logic              fb_sel_q, fb_sel_d;

    always_comb begin
        mem_addr_d = mem_addr_q;
        if (tag0.active) begin
            mem_addr_d = ADDR_W'({fb_sel_q, pix_idx});
        end
        // Swap only at the first vblank pixel so a frame is never torn
        fb_sel_d = fb_sel_q;
        if ((hcnt_i == 10'd0) && (vcnt_i == 10'd480)) begin
            fb_sel_d = fb_sel_req_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_addr_q <= '0;
            mem_en_q   <= 1'b0;
            fb_sel_q   <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_en_q   <= tag0.active;
            fb_sel_q   <= fb_sel_d;
        end
    end

    // Decode tags ride alongside the memory read so they meet mem_data
    tag_t dl_q [MEM_LAT+1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= MEM_LAT; i++) begin
                dl_q[i] <= TAG_IDLE;
            end
        end else begin
            dl_q[0] <= tag0;
            for (int i = 1; i <= MEM_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    // Output stage: colour select and final DAC registers
    tag_t        tag_out;
    logic [2:0]  bar;
    logic [11:0] rgb_d, rgb_q;
    logic        hs_q, vs_q, vb_q, fs_q;

    assign tag_out = dl_q[MEM_LAT];

    always_comb begin
        bar = 3'd7;
        if (tag_out.h < 10'd80) begin
            bar = 3'd0;
        end else if (tag_out.h < 10'd160) begin
            bar = 3'd1;
        end else if (tag_out.h < 10'd240) begin
            bar = 3'd2;
        end else if (tag_out.h < 10'd320) begin
            bar = 3'd3;
        end else if (tag_out.h < 10'd400) begin
            bar = 3'd4;
        end else if (tag_out.h < 10'd480) begin
            bar = 3'd5;
        end else if (tag_out.h < 10'd560) begin
            bar = 3'd6;
        end

        rgb_d = 12'h000;
        if (tag_out.active) begin
            if (pattern_en_i) begin
                rgb_d = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            end else begin
                rgb_d = mem_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vb_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= tag_out.hs_n;
            vs_q  <= tag_out.vs_n;
            vb_q  <= tag_out.vb;
            fs_q  <= tag_out.fs;
        end
    end

    assign mem_addr_o    = mem_addr_q;
    assign mem_en_o      = mem_en_q;
    assign fb_sel_cur_o  = fb_sel_q;
    assign vga_r_o       = rgb_q[11:8];
    assign vga_g_o       = rgb_q[7:4];
    assign vga_b_o       = rgb_q[3:0];
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vblank_o      = vb_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: two instances (read latency 2 and 3) driven by the same scan
// positions and checked against a scan-position history model and latency-matched memory models.
module tb_vga_pixel_pipe;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst;
    logic [9:0] hcnt, vcnt;
    logic       fb_req, pat;

    logic [15:0] a2, a3;
    logic        en2, en3;
    logic [11:0] md2, md3;
    logic [3:0]  r2, g2, b2, r3, g3, b3;
    logic        hs2, vs2, vb2, fs2, fbc2;
    logic        hs3, vs3, vb3, fs3, fbc3;

    vga_pixel_pipe #(.MEM_LAT(2), .ADDR_W(16)) u2 (
        .clk_i(clk), .rst_i(rst), .hcnt_i(hcnt), .vcnt_i(vcnt),
        .fb_sel_req_i(fb_req), .pattern_en_i(pat),
        .mem_addr_o(a2), .mem_en_o(en2), .mem_data_i(md2),
        .vga_r_o(r2), .vga_g_o(g2), .vga_b_o(b2),
        .vga_hs_o(hs2), .vga_vs_o(vs2), .vblank_o(vb2),
        .frame_start_o(fs2), .fb_sel_cur_o(fbc2)
    );

    vga_pixel_pipe #(.MEM_LAT(3), .ADDR_W(16)) u3 (
        .clk_i(clk), .rst_i(rst), .hcnt_i(hcnt), .vcnt_i(vcnt),
        .fb_sel_req_i(fb_req), .pattern_en_i(pat),
        .mem_addr_o(a3), .mem_en_o(en3), .mem_data_i(md3),
        .vga_r_o(r3), .vga_g_o(g3), .vga_b_o(b3),
        .vga_hs_o(hs3), .vga_vs_o(vs3), .vblank_o(vb3),
        .frame_start_o(fs3), .fb_sel_cur_o(fbc3)
    );

    // Memories return the low 12 address bits, latency counted from the registered address
    logic [11:0] p2 [2];
    logic [11:0] p3 [3];
    always @(posedge clk) begin
        p2[0] <= a2[11:0];
        p2[1] <= p2[0];
        p3[0] <= a3[11:0];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign md2 = p2[1];
    assign md3 = p3[2];

    typedef struct {
        bit valid;
        int h;
        int v;
    } ent_t;

    ent_t hist[$];
    int   checks = 0;
    int   errors = 0;
    int   mfb;
    int   exp_addr;
    int   exp_en;
    int   hs_low;
    bit   count_hs;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int ref_rgb(ent_t e, bit p);
        int bar;
        if (!e.valid || !(e.h < 640 && e.v < 480)) return 0;
        if (p) begin
            bar = e.h / 80;
            return (bar[2] ? 'hF00 : 0) | (bar[1] ? 'h0F0 : 0) | (bar[0] ? 'h00F : 0);
        end
        return ((e.v / 4) * 160 + e.h / 4) % 4096;
    endfunction

    task automatic check_dut(input string nm, input int lat, input int addr, input int en,
                             input int rgb, input int hs, input int vs, input int vb,
                             input int fs, input int fbc);
        ent_t e;
        int   xrgb, xhs, xvs, xvb, xfs;
        bit   inr;
        e    = hist[lat+1];
        inr  = (e.h < 800) && (e.v < 521);
        xrgb = ref_rgb(e, pat);
        xhs  = !(e.valid && inr && e.h >= 656 && e.h <= 751);
        xvs  = !(e.valid && inr && e.v >= 490 && e.v <= 491);
        xvb  = e.valid && (e.v >= 480);
        xfs  = e.valid && (e.h == 0) && (e.v == 0);
        if (rst) begin
            xrgb = 0; xhs = 1; xvs = 1; xvb = 0; xfs = 0;
        end
        chk({nm, "_addr"}, addr, exp_addr);
        chk({nm, "_en"}, en, exp_en);
        chk({nm, "_fbcur"}, fbc, mfb);
        chk({nm, "_rgb"}, rgb, xrgb);
        chk({nm, "_hs"}, hs, xhs);
        chk({nm, "_vs"}, vs, xvs);
        chk({nm, "_vblank"}, vb, xvb);
        chk({nm, "_fstart"}, fs, xfs);
    endtask

    // One clock: apply (h,v) at the falling edge, advance, check both instances
    task automatic tick(input int h, input int v);
        ent_t e;
        hcnt    = 10'(h);
        vcnt    = 10'(v);
        e.valid = !rst;
        e.h     = h;
        e.v     = v;
        hist.push_front(e);
        if (hist.size() > 8) void'(hist.pop_back());
        if (rst) begin
            exp_addr = 0; exp_en = 0; mfb = 0;
        end else begin
            exp_en = (h < 640 && v < 480);
            if (exp_en != 0) exp_addr = (mfb << 15) + (v / 4) * 160 + h / 4;
            if (h == 0 && v == 480) mfb = fb_req;
        end
        @(posedge clk);
        @(negedge clk);
        check_dut("L2", 2, a2, en2, {r2, g2, b2}, hs2, vs2, vb2, fs2, fbc2);
        check_dut("L3", 3, a3, en3, {r3, g3, b3}, hs3, vs3, vb3, fs3, fbc3);
        if (count_hs && !hs2) hs_low++;
    endtask

    task automatic seg(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) tick(h, v);
    endtask

    initial begin
        int   fs_at2, fs_at3;
        ent_t blank;
        blank.valid = 0; blank.h = 0; blank.v = 0;
        for (int i = 0; i < 8; i++) hist.push_front(blank);
        rst = 1'b1; hcnt = '0; vcnt = '0; fb_req = 1'b0; pat = 1'b0;
        mfb = 0; exp_addr = 0; exp_en = 0; hs_low = 0; count_hs = 0;

        // Reset held, then released into a free-running line 0
        for (int i = 0; i < 3; i++) tick(0, 0);
        rst = 1'b0;
        fs_at2 = -1; fs_at3 = -1;
        for (int h = 0; h < 800; h++) begin
            tick(h, 0);
            if (fs2 && fs_at2 < 0) fs_at2 = h + 1;
            if (fs3 && fs_at3 < 0) fs_at3 = h + 1;
        end
        chk("fstart_lat2", fs_at2, 4);
        chk("fstart_lat3", fs_at3, 5);

        // Lines 10 and 11: hsync width and address values
        count_hs = 1;
        for (int h = 0; h < 800; h++) begin
            tick(h, 10);
            if (h == 639) chk("addr_h639", a2, 479);
        end
        seg(11, 0, 799);
        count_hs = 0;
        chk("hs_low_2lines", hs_low, 192);

        // Buffer swap: request raised mid-frame, honoured only at (0,480)
        seg(200, 0, 49);
        fb_req = 1'b1;
        seg(200, 50, 99);
        chk("fb_hold_midframe", fbc2, 0);
        for (int v = 470; v < 480; v++) seg(v, 630, 641);
        tick(639, 479);
        chk("addr_max", a2, 19199);
        tick(0, 480);
        fb_req = 1'b0;
        chk("fb_swap", fbc2, 1);
        for (int v = 481; v < 521; v++) begin
            seg(v, 0, 7);
            seg(v, 636, 660);
            seg(v, 748, 799);
        end
        seg(0, 0, 20);
        chk("fb_bit15_next", a2[15], 1);

        // Randomized scan positions, pattern and swap requests
        for (int i = 0; i < 3000; i++) begin
            int h, v;
            h = $urandom_range(0, 799);
            v = $urandom_range(0, 520);
            if ($urandom_range(0, 15) == 0) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end
            if ($urandom_range(0, 49) == 0) begin
                h = 0;
                v = 480;
            end
            pat    = 1'($urandom_range(0, 1));
            fb_req = 1'($urandom_range(0, 1));
            tick(h, v);
        end

        // Colour-bar pattern over a whole line
        pat = 1'b1;
        seg(100, 0, 799);

        // Asynchronous reset mid-line while a bar is being shown
        seg(50, 0, 299);
        hcnt = 10'd300;
        rst  = 1'b1;
        #1;
        chk("async_rst_rgb2", {r2, g2, b2}, 0);
        chk("async_rst_hs2", hs2, 1);
        chk("async_rst_vs2", vs2, 1);
        chk("async_rst_rgb3", {r3, g3, b3}, 0);
        tick(300, 50);
        for (int i = 0; i < 3; i++) tick(301 + i, 50);
        rst = 1'b0;
        pat = 1'b0;
        seg(50, 304, 799);
        seg(51, 0, 799);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
